// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-requester front end for a 512x8 single-port SRAM macro
// (active-low CEN/GWEN/WEN). One access is issued per cycle through registered
// macro pins. Read data returns to the issuing requester 3 cycles after acceptance.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration. When it is
// undefined, r0 has fixed priority over r1.
module sram_port_arbiter #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic          sram_cen,
    output logic          sram_gwen,
    output logic [DW-1:0] sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    // Requester identity carried alongside each access.
    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_t;

    // Read-return tag: one per pipeline stage.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    logic          win_valid;
    req_id_t       win_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    tag_t          tag_issue;
    tag_t          tag_capture;

`ifdef SRAM_ARB_RR_EN
    req_id_t       last_gnt;

    // Remember the most recent winner. Reset makes r1 "last", so r0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= REQ_R1;
        end else if (r0_gnt) begin
            last_gnt <= REQ_R0;
        end else if (r1_gnt) begin
            last_gnt <= REQ_R1;
        end
    end

    // Round-robin grant: on contention the requester not granted last wins.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (r0_req && r1_req) begin
            if (last_gnt == REQ_R1) begin
                r0_gnt = 1'b1;
            end else begin
                r1_gnt = 1'b1;
            end
        end else begin
            r0_gnt = r0_req;
            r1_gnt = r1_req;
        end
    end
`else
    // Fixed-priority grant: r0 always wins, and r1 only uses idle r0 cycles.
    always_comb begin
        r0_gnt = r0_req;
        r1_gnt = r1_req & ~r0_req;
    end
`endif

    // Select the winning requester's command fields.
    always_comb begin
        win_valid = r0_gnt | r1_gnt;
        win_id    = REQ_R0;
        win_we    = r0_we;
        win_addr  = r0_addr;
        win_wdata = r0_wdata;
        if (r1_gnt) begin
            win_id    = REQ_R1;
            win_we    = r1_we;
            win_addr  = r1_addr;
            win_wdata = r1_wdata;
        end
    end

    // Macro command register. In idle cycles the address and data pins hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_a    <= '0;
            sram_d    <= '0;
        end else if (win_valid) begin
            sram_cen  <= 1'b0;
            sram_gwen <= ~win_we;
            sram_wen  <= win_we ? '0 : '1;
            sram_a    <= win_addr;
            sram_d    <= win_wdata;
        end else begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
        end
    end

    // Two-stage read tag pipeline. Issue follows the pin register, and capture
    // follows the macro's sampling edge. Writes never enter the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_issue   <= '0;
            tag_capture <= '0;
        end else begin
            tag_issue.valid <= win_valid & ~win_we;
            tag_issue.id    <= win_id;
            tag_capture     <= tag_issue;
        end
    end

    // Route macro Q to the tagged requester and pulse its rvalid for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            r0_rvalid <= tag_capture.valid && (tag_capture.id == REQ_R0);
            r1_rvalid <= tag_capture.valid && (tag_capture.id == REQ_R1);
            if (tag_capture.valid && (tag_capture.id == REQ_R0)) begin
                r0_rdata <= sram_q;
            end
            if (tag_capture.valid && (tag_capture.id == REQ_R1)) begin
                r1_rdata <= sram_q;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural 512x8 macro.
// Expectations follow SRAM_ARB_RR_EN when it is defined.
module tb_sram_port_arbiter;

    logic       clk;
    logic       rst;
    logic       r0_req, r1_req;
    logic       r0_we, r1_we;
    logic [8:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic       r0_gnt, r1_gnt;
    logic       r0_rvalid, r1_rvalid;
    logic [7:0] r0_rdata, r1_rdata;
    logic       sram_cen, sram_gwen;
    logic [7:0] sram_wen;
    logic [8:0] sram_a;
    logic [7:0] sram_d;
    logic [7:0] sram_q;

    int checks;
    int errors;

    logic [7:0] mem [0:511];

    sram_port_arbiter #(.AW(9), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_req    (r0_req),
        .r1_req    (r1_req),
        .r0_we     (r0_we),
        .r1_we     (r1_we),
        .r0_addr   (r0_addr),
        .r1_addr   (r1_addr),
        .r0_wdata  (r0_wdata),
        .r1_wdata  (r1_wdata),
        .r0_gnt    (r0_gnt),
        .r1_gnt    (r1_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_rvalid (r1_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_rdata  (r1_rdata),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: samples the pins at the rising edge, and Q is valid in the following cycle.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        r0_req = 1'b0; r1_req = 1'b0;
        r0_we = 1'b0;  r1_we = 1'b0;
        r0_addr = '0;  r1_addr = '0;
        r0_wdata = '0; r1_wdata = '0;
    endtask

    logic eg0 [0:10];
    logic eg1 [0:10];

    initial begin
        checks = 0;
        errors = 0;
        sram_q = '0;
        idle_inputs();
        rst = 1'b1;

        // Reset state.
        #2;
        check("rst_cen", 32'(sram_cen), 'h1);
        check("rst_gwen", 32'(sram_gwen), 'h1);
        check("rst_wen", 32'(sram_wen), 'hFF);
        check("rst_a", 32'(sram_a), 'h0);
        check("rst_d", 32'(sram_d), 'h0);
        check("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 'h0);
        check("rst_rdata", 32'({r0_rdata, r1_rdata}), 'h0);
        check("rst_gnt_noreq", 32'({r0_gnt, r1_gnt}), 'h0);
        @(negedge clk);
        rst = 1'b0;

        // r0 writes 0x1A5 <- 3C, then reads it back.
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 9'h1A5; r0_wdata = 8'h3C;
        #1 check("wr_gnt", 32'({r0_gnt, r1_gnt}), 'h2);
        @(negedge clk);
        check("wr_pins", 32'({sram_cen, sram_gwen, sram_wen}), 'h000);
        check("wr_a", 32'(sram_a), 'h1A5);
        check("wr_d", 32'(sram_d), 'h3C);
        r0_we = 1'b0; r0_wdata = 8'h00;
        #1 check("rd_gnt", 32'({r0_gnt, r1_gnt}), 'h2);
        @(negedge clk);
        check("rd_pins", 32'({sram_cen, sram_gwen, sram_wen}), 'h1FF);
        check("rd_a", 32'(sram_a), 'h1A5);
        idle_inputs();
        check("rd_rvalid_t1", 32'({r0_rvalid, r1_rvalid}), 'h0);
        @(negedge clk);
        check("rd_rvalid_t2", 32'({r0_rvalid, r1_rvalid}), 'h0);
        check("idle_pins", 32'({sram_cen, sram_gwen, sram_wen}), 'h3FF);
        check("idle_a_hold", 32'(sram_a), 'h1A5);
        @(negedge clk);
        check("rd_rvalid_t3", 32'({r0_rvalid, r1_rvalid}), 'h2);
        check("rd_rdata", 32'(r0_rdata), 'h3C);
        @(negedge clk);
        check("rd_rvalid_pulse", 32'({r0_rvalid, r1_rvalid}), 'h0);
        check("rd_rdata_hold", 32'(r0_rdata), 'h3C);

        // r1 preloads 0x000 <- C3 and 0x1FF <- 7E, which leaves r1 as the last grant.
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 9'h000; r1_wdata = 8'hC3;
        #1 check("pre0_gnt", 32'({r0_gnt, r1_gnt}), 'h1);
        @(negedge clk);
        r1_addr = 9'h1FF; r1_wdata = 8'h7E;
        #1 check("pre1_gnt", 32'({r0_gnt, r1_gnt}), 'h1);
        @(negedge clk);

        // Contention: both requesters read for 6 cycles.
        for (int j = 0; j <= 10; j++) begin
`ifdef SRAM_ARB_RR_EN
            eg0[j] = (j < 6) && (j % 2 == 0);
            eg1[j] = (j < 6) && (j % 2 == 1);
`else
            eg0[j] = (j < 6);
            eg1[j] = (j == 6);
`endif
        end
        r0_we = 1'b0; r0_addr = 9'h000;
        r1_we = 1'b0; r1_addr = 9'h1FF; r1_wdata = 8'h00;
        for (int j = 0; j <= 10; j++) begin
            r0_req = (j < 6);
`ifdef SRAM_ARB_RR_EN
            r1_req = (j < 6);
`else
            r1_req = (j < 7);
`endif
            #1;
            check($sformatf("cont_gnt%0d", j), 32'({r0_gnt, r1_gnt}), 32'({eg0[j], eg1[j]}));
            if (j >= 3) begin
                check($sformatf("cont_rv%0d", j), 32'({r0_rvalid, r1_rvalid}),
                      32'({eg0[j-3], eg1[j-3]}));
                if (eg0[j-3]) check($sformatf("cont_rd0_%0d", j), 32'(r0_rdata), 'hC3);
                if (eg1[j-3]) check($sformatf("cont_rd1_%0d", j), 32'(r1_rdata), 'h7E);
            end
            @(negedge clk);
        end
        idle_inputs();

        // Read-after-write: r1 writes 0x010 <- AA, then r0 reads it in the next cycle.
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 9'h010; r1_wdata = 8'hAA;
        #1 check("raw_wgnt", 32'({r0_gnt, r1_gnt}), 'h1);
        @(negedge clk);
        idle_inputs();
        r0_req = 1'b1; r0_addr = 9'h010;
        #1 check("raw_rgnt", 32'({r0_gnt, r1_gnt}), 'h2);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("raw_rvalid", 32'({r0_rvalid, r1_rvalid}), 'h2);
        check("raw_rdata", 32'(r0_rdata), 'hAA);
        @(negedge clk);

        // Reset with two reads in flight.
        r0_req = 1'b1; r0_addr = 9'h000;
        @(negedge clk);
        idle_inputs();
        r1_req = 1'b1; r1_addr = 9'h1FF;
        @(negedge clk);
        idle_inputs();
        check("inflight_cen", 32'(sram_cen), 'h0);
        #1 rst = 1'b1;
        #1;
        check("async_cen", 32'(sram_cen), 'h1);
        check("async_wen", 32'(sram_wen), 'hFF);
        check("async_a", 32'(sram_a), 'h0);
        check("async_rvalid", 32'({r0_rvalid, r1_rvalid}), 'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_rv%0d", k), 32'({r0_rvalid, r1_rvalid}), 'h0);
            check($sformatf("post_rst_cen%0d", k), 32'(sram_cen), 'h1);
        end

        // After reset, r0 wins the first contention.
        r0_req = 1'b1; r1_req = 1'b1; r0_addr = 9'h1A5; r1_addr = 9'h010;
        #1 check("post_rst_first_gnt", 32'({r0_gnt, r1_gnt}), 'h2);
        @(negedge clk);
        idle_inputs();
        check("post_rst_cmd", 32'({sram_cen, sram_a}), 'h1A5);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_rd_rvalid", 32'({r0_rvalid, r1_rvalid}), 'h2);
        check("post_rst_rd_data", 32'(r0_rdata), 'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares one `gf180mcu_fd_ip_sram__sram512x8m8wm1` macro (512 x 8, active-low CEN/GWEN/WEN) between independent read/write clients. It sits directly in front of the macro and owns all of its control pins. It drives registered macro inputs, with one access issued per cycle, and returns read data to the issuing requester with fixed latency.

## Interface
Parameters:
- `AW`, 9: address width; must match the macro depth of 512.
- `DW`, 8: data width; must match the macro width of 8.

Ports:
- `clk` in 1: single clock; also drives macro `CLK`.
- `rst` in 1: reset, asynchronous, active-high.
- `r0_req`, `r1_req` in 1: access request; held until granted.
- `r0_we`, `r1_we` in 1: 1 = write, 0 = read.
- `r0_addr`, `r1_addr` in AW: word address.
- `r0_wdata`, `r1_wdata` in DW: write data.
- `r0_gnt`, `r1_gnt` out 1: combinational grant; the access is accepted in a cycle where `req & gnt`.
- `r0_rvalid`, `r1_rvalid` out 1: one-cycle pulse; `rN_rdata` is valid.
- `r0_rdata`, `r1_rdata` out DW: registered read data, held until the next rvalid for that requester.
- `sram_cen` out 1: to macro `CEN`, active low.
- `sram_gwen` out 1: to macro `GWEN`, active low.
- `sram_wen` out DW: to macro `WEN`, active low per bit.
- `sram_a` out AW: to macro `A`.
- `sram_d` out DW: to macro `D`.
- `sram_q` in DW: from macro `Q`.

## Operation
- Arbitration is combinational in cycle T, over `r0_req` and `r1_req`.
  - At most one `gnt` is high.
  - `gnt` is never high without its `req`.
  - A lone requester is always granted.
- Command register captures the winner at the posedge ending T:
  - `sram_cen` = 0 (access); otherwise 1.
  - Write: `sram_gwen` = 0, `sram_wen` = 8'h00.
  - Read: `sram_gwen` = 1, `sram_wen` = 8'hFF.
  - `sram_a` and `sram_d` take the winner's address and data.
- Idle cycle: `sram_cen` = 1, `sram_gwen` = 1, `sram_wen` = 8'hFF; `sram_a` and `sram_d` hold their previous values.
- Read pipeline: a 2-stage tag shift register {valid, requester id}, with stages issue and capture.
  - The capture stage registers `sram_q` into the tagged `rN_rdata` and pulses `rN_rvalid`.
  - Writes produce no rvalid.
- Ordering is strictly in issue order.
  - A read issued the cycle after a write to the same address returns the new data.
  - A write accepted in the same cycle as a read is not possible, since only one grant exists per cycle.
- Reset values:
  - gnt/rvalid = 0, rdata = 0.
  - `sram_cen` = 1, `sram_gwen` = 1, `sram_wen` = 8'hFF, `sram_a` = 0, `sram_d` = 0.
  - Pipeline tags cleared; priority pointer = "r1 last granted", so r0 wins first.
- Reset mid-operation: in-flight reads are dropped, with no rvalid after reset deasserts. A write already presented to the macro at the reset edge is not guaranteed to complete.

## Timing
- Accept at cycle T (`req & gnt`).
- Macro pins are driven during T+1 and sampled by the macro at the end of T+1.
- `sram_q` is valid during T+2 and is captured at the end of T+2.
- `rN_rvalid` is high during T+3. Read latency is 3 cycles from acceptance.
- Throughput is 1 access per cycle with back-to-back grants. A requester may hold `req` continuously and is granted whenever it wins.
- `rvalid` for two different requesters never coincides; `rvalid` for one requester may be high on consecutive cycles.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - When both request, the requester not granted last wins.
  - The pointer updates only on a grant.
  - Under continuous dual requests, grants alternate r0, r1, r0, ...
- `SRAM_ARB_RR_EN` undefined: fixed priority, with r0 always winning.
  - r1 is granted only in cycles where `r0_req` = 0.
  - No pointer register is instantiated.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle. Outputs go to reset values immediately: `sram_cen` = 1, `sram_wen` = 8'hFF, all rvalid = 0.
- Single-requester write then read:
  - r0 writes 0x1A5 <- 8'h3C.
  - r0 reads 0x1A5 the next cycle.
  - Expect `r0_rvalid` exactly 3 cycles after the read acceptance, `r0_rdata` = 8'h3C, and `r1_rvalid` never high.
- Contention, RR built:
  - Both requesters hold reads to 0x000 (r0) and 0x1FF (r1) for 6 cycles.
  - Expect grants r0, r1, r0, r1, r0, r1.
  - Expect rvalids in the same order, each carrying its own address's data.
- Contention, RR not built: same stimulus. Expect `r0_gnt` = 1 on all 6 cycles and `r1_gnt` = 0 until `r0_req` drops.
- Read-after-write hazard:
  - r1 writes 0x010 <- 8'hAA.
  - r0 reads 0x010 the next cycle.
  - Expect `r0_rdata` = 8'hAA.
- Reset with 2 reads in flight: assert `rst` one cycle after the second acceptance. Expect no rvalid after release and `sram_cen` = 1 until the next grant.
